key_ctrl: RTL and testbench
===========================

KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- OCT_DEFAULT, 4, octave after reset or clear
- OCT_MAX, 7, highest octave
- REPEAT_CYCLES, 25000000, hold-repeat period in clk cycles
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous assert, active low
- note_switches  in  7  registered switch levels, bit6=C, bit5=D, bit4=E, bit3=F, bit2=G, bit1=A, bit0=B
- rst  in  1  registered clear-button level
- toggle_pb  in  1  registered playback-button level
- inc_octave  in  1  registered octave-up button level
- dec_octave  in  1  registered octave-down button level
- octave  out  3  current octave, 0..OCT_MAX
- playback  out  1  playback mode flag
- note_on  out  1  at least one note switch active
- note_idx  out  3  active note, 0=C through 6=B
- note_change  out  1  one-cycle pulse when {note_on, note_idx} changes

Function
REQ-003 Each button input (rst, toggle_pb, inc_octave, dec_octave) has a previous-level register. An event occurs on the clk edge where level=1 and previous=0.
REQ-004 Previous-level registers reset to 1, so a button held through reset release generates no event.
REQ-005 Clear event: octave<=OCT_DEFAULT and playback<=0. Clear overrides inc, dec and toggle events in the same cycle.
REQ-006 Toggle event: playback<=~playback on the same edge.
REQ-007 Inc event alone: octave increments by 1 and saturates at OCT_MAX.
REQ-008 Dec event alone: octave decrements by 1 and saturates at 0.
REQ-009 Inc and dec events on the same edge: octave is unchanged.
REQ-010 Inc level and dec level both 1 (either order): no octave step occurs, including repeat steps.
REQ-011 Note encoding is a priority encoder; the lowest note index wins (bit6/C highest priority). With no switch active, note_on=0 and note_idx holds its last value.
REQ-012 note_on and note_idx are registered, with 1-cycle latency from note_switches.
REQ-013 note_change=1 for exactly one cycle, on the edge after note_on or note_idx takes a new value. It is never asserted in the first cycle after reset release.
REQ-014 Octave and playback latency: the output changes on the same clk edge that detects the event (0 cycles after sampling).

Reset
REQ-015 While rst_n=0, outputs take these values asynchronously:
- octave=OCT_DEFAULT
- playback=0
- note_on=0
- note_idx=0
- note_change=0
- repeat counter=0
- previous-level registers=1
REQ-016 Asserting rst_n mid-operation aborts any repeat in progress. A fresh press edge is required after release.

Configuration
REQ-017 Macro HOLD_REPEAT_EN, when defined, enables auto-repeat:
- With inc_octave or dec_octave held alone, a counter runs from its press event.
- Each REPEAT_CYCLES consecutive held cycles generate one further step, with the same saturation rules.
- The counter clears on release, on both held, or on a clear event.
REQ-018 Without HOLD_REPEAT_EN:
- No repeat counter exists.
- Exactly one step occurs per press, regardless of hold duration.

Verification
REQ-019 The bench shall cover these directed scenarios (REPEAT_CYCLES=8 where repeat is involved):
- Reset release with inc_octave=1 held -> octave stays 4; release then press -> octave=5.
- 5 inc presses from 4 -> octave 5, 6, 7, 7, 7; 9 dec presses -> octave ends at 0.
- inc and dec rising on the same edge -> octave unchanged; rst and toggle_pb rising together -> playback=0, octave=4.
- note_switches=0b0010100 -> note_on=1, note_idx=2 one cycle later with a 1-cycle note_change pulse; then 0b0000000 -> note_on=0, note_idx=2, pulse.
- HOLD_REPEAT_EN, inc held 20 cycles from octave 0 -> octave=1 at the press edge, 2 at +8, 3 at +16; release -> no further change.
- rst_n pulsed low while inc is held with repeat active -> octave=4 immediately; no step until release and re-press.

Source files
------------

// File: rtl/key_ctrl.sv
// rtl/key_ctrl.sv - octave/playback/note front-end for a switch-and-button keyboard
//
// Purpose:
//   Turns button levels into press events that step the octave and toggle
//   playback mode. A clear press restores the default octave and leaves
//   playback mode. The note switches are priority-encoded into a
//   registered note, and a one-cycle pulse marks every note change.
//   Optional macro HOLD_REPEAT_EN: holding octave-up or octave-down on its
//   own repeats the step every REPEAT_CYCLES clocks.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   note_switches in 7 switch levels, bit6=C ... bit0=B
//   rst           in   clear-button level
//   toggle_pb     in   playback-button level
//   inc_octave    in   octave-up button level
//   dec_octave    in   octave-down button level
//   octave        out 3 current octave, 0..OCT_MAX
//   playback      out  playback mode flag
//   note_on       out  at least one note switch active
//   note_idx      out 3 active note, 0=C .. 6=B (held while no switch is on)
//   note_change   out  one-cycle pulse after {note_on, note_idx} changes
module key_ctrl #(
  parameter int OCT_DEFAULT   = 4,
  parameter int OCT_MAX       = 7,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] note_switches,
  input  logic       rst,
  input  logic       toggle_pb,
  input  logic       inc_octave,
  input  logic       dec_octave,
  output logic [2:0] octave,
  output logic       playback,
  output logic       note_on,
  output logic [2:0] note_idx,
  output logic       note_change
);

  localparam logic [2:0] OCT_DEF_V = 3'(OCT_DEFAULT);
  localparam logic [2:0] OCT_MAX_V = 3'(OCT_MAX);

  // Previous button levels. They reset to 1 so that a button held through
  // reset release does not count as a press.
  logic clr_prev_q, clr_prev_d;
  logic tog_prev_q, tog_prev_d;
  logic inc_prev_q, inc_prev_d;
  logic dec_prev_q, dec_prev_d;

  logic [2:0] octave_q, octave_d;
  logic       playback_q, playback_d;
  logic       note_on_q, note_on_d;
  logic [2:0] note_idx_q, note_idx_d;
  logic [3:0] note_last_q, note_last_d;
  logic       note_change_q, note_change_d;

  logic clr_ev, tog_ev, inc_ev, dec_ev, both_held;
  logic step_up, step_dn;
  logic [2:0] enc_idx;

  always_comb begin
    clr_prev_d = rst;
    tog_prev_d = toggle_pb;
    inc_prev_d = inc_octave;
    dec_prev_d = dec_octave;
    clr_ev     = rst & ~clr_prev_q;
    tog_ev     = toggle_pb & ~tog_prev_q;
    inc_ev     = inc_octave & ~inc_prev_q;
    dec_ev     = dec_octave & ~dec_prev_q;
    // Both octave buttons down cancels every step, whichever was first.
    both_held  = inc_octave & dec_octave;
  end

`ifdef HOLD_REPEAT_EN
  localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  // rep_act marks a hold that began with a real press; a level that was
  // already high at reset release never arms the repeat.
  logic          rep_act_q, rep_act_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire;

  always_comb begin
    rep_act_d = rep_act_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (clr_ev || both_held || !(inc_octave || dec_octave)) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (inc_ev || dec_ev) begin
      rep_act_d = 1'b1;
      rep_cnt_d = '0;
    end else if (rep_act_q) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
    step_up = (inc_ev | (rep_fire & inc_octave)) & ~both_held;
    step_dn = (dec_ev | (rep_fire & dec_octave)) & ~both_held;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_act_q <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  always_comb begin
    step_up = inc_ev & ~both_held;
    step_dn = dec_ev & ~both_held;
  end
`endif

  // Octave and playback update on the edge that detects the event.
  always_comb begin
    octave_d   = octave_q;
    playback_d = playback_q;
    if (clr_ev) begin
      octave_d   = OCT_DEF_V;
      playback_d = 1'b0;
    end else begin
      if (tog_ev) playback_d = ~playback_q;
      if (step_up && octave_q < OCT_MAX_V) octave_d = octave_q + 3'd1;
      else if (step_dn && octave_q != 3'd0) octave_d = octave_q - 3'd1;
    end
  end

  // Lowest note index (bit6 = C) wins.
  always_comb begin
    casez (note_switches)
      7'b1??????: enc_idx = 3'd0;
      7'b01?????: enc_idx = 3'd1;
      7'b001????: enc_idx = 3'd2;
      7'b0001???: enc_idx = 3'd3;
      7'b00001??: enc_idx = 3'd4;
      7'b000001?: enc_idx = 3'd5;
      default:    enc_idx = 3'd6;
    endcase
    note_on_d  = |note_switches;
    note_idx_d = note_on_d ? enc_idx : note_idx_q;
    // Compare the registered note with its value one edge earlier, so the
    // pulse follows the edge where the note output changed.
    note_last_d   = {note_on_q, note_idx_q};
    note_change_d = ({note_on_q, note_idx_q} != note_last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_prev_q    <= 1'b1;
      tog_prev_q    <= 1'b1;
      inc_prev_q    <= 1'b1;
      dec_prev_q    <= 1'b1;
      octave_q      <= OCT_DEF_V;
      playback_q    <= 1'b0;
      note_on_q     <= 1'b0;
      note_idx_q    <= 3'd0;
      note_last_q   <= 4'd0;
      note_change_q <= 1'b0;
    end else begin
      clr_prev_q    <= clr_prev_d;
      tog_prev_q    <= tog_prev_d;
      inc_prev_q    <= inc_prev_d;
      dec_prev_q    <= dec_prev_d;
      octave_q      <= octave_d;
      playback_q    <= playback_d;
      note_on_q     <= note_on_d;
      note_idx_q    <= note_idx_d;
      note_last_q   <= note_last_d;
      note_change_q <= note_change_d;
    end
  end

  assign octave      = octave_q;
  assign playback    = playback_q;
  assign note_on     = note_on_q;
  assign note_idx    = note_idx_q;
  assign note_change = note_change_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb/tb_key_ctrl.sv - scoreboard bench for key_ctrl
module tb_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] note_switches;
  logic       rst, toggle_pb, inc_octave, dec_octave;
  logic [2:0] octave;
  logic       playback, note_on;
  logic [2:0] note_idx;
  logic       note_change;

  key_ctrl #(.OCT_DEFAULT(4), .OCT_MAX(7), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .note_switches(note_switches), .rst(rst),
    .toggle_pb(toggle_pb), .inc_octave(inc_octave), .dec_octave(dec_octave),
    .octave(octave), .playback(playback), .note_on(note_on),
    .note_idx(note_idx), .note_change(note_change)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  oct;
    logic        pb;
    logic        on;
    logic [2:0]  idx;
    logic        chg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passed = 0;
  bit    finishing = 0;
  bit    mon_done = 0;
  exp_t  e;
  string nm;

`ifdef HOLD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are settled at the falling edge; pop every expectation
  // belonging to the current cycle and compare.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (int'(e.cyc) != cyc)
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", nm, e.cyc, cyc);
      else if ({octave, playback, note_on, note_idx, note_change} !== {e.oct, e.pb, e.on, e.idx, e.chg})
        $display("FAIL %s: got oct=%0d pb=%0b on=%0b idx=%0d chg=%0b, want oct=%0d pb=%0b on=%0b idx=%0d chg=%0b",
                 nm, octave, playback, note_on, note_idx, note_change, e.oct, e.pb, e.on, e.idx, e.chg);
      else
        passed++;
    end
    if (finishing && !mon_done) begin
      while (name_q.size() > 0) begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        checks++;
        $display("FAIL %s: expectation never checked, got nothing, want cycle %0d", nm, e.cyc);
      end
      mon_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int oct, input bit pb,
                            input bit on, input int idx, input bit chg);
    exp_t x;
    x.cyc = 32'(cyc);
    x.oct = 3'(oct);
    x.pb  = pb;
    x.on  = on;
    x.idx = 3'(idx);
    x.chg = chg;
    exp_q.push_back(x);
    name_q.push_back(name);
  endtask

  task automatic press_inc(input string name, input int oct, input bit pb, input int idx);
    inc_octave = 1'b1; tick(1);
    expect_now(name, oct, pb, 1'b0, idx, 1'b0);
    inc_octave = 1'b0; tick(1);
  endtask

  task automatic press_dec(input string name, input int oct, input bit pb, input int idx);
    dec_octave = 1'b1; tick(1);
    expect_now(name, oct, pb, 1'b0, idx, 1'b0);
    dec_octave = 1'b0; tick(1);
  endtask

  task automatic press_clr(input int idx);
    rst = 1'b1; tick(1);
    expect_now("clear", 4, 1'b0, 1'b0, idx, 1'b0);
    rst = 1'b0; tick(1);
  endtask

  int inc_exp[5] = '{5, 6, 7, 7, 7};
  int dec_exp[9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    rst_n = 1'b0; note_switches = 7'd0; rst = 1'b0; toggle_pb = 1'b0;
    inc_octave = 1'b1; dec_octave = 1'b0;
    tick(2);
    expect_now("reset_values", 4, 0, 0, 0, 0);

    // Held through reset release: no event.
    rst_n = 1'b1; tick(3);
    expect_now("held_through_reset", 4, 0, 0, 0, 0);
    inc_octave = 1'b0; tick(1);
    inc_octave = 1'b1; tick(1);
    expect_now("press_after_release", 5, 0, 0, 0, 0);
    inc_octave = 1'b0; tick(1);

    press_clr(0);
    for (int i = 0; i < 5; i++) press_inc($sformatf("inc_sat_%0d", i), inc_exp[i], 1'b0, 0);
    for (int i = 0; i < 9; i++) press_dec($sformatf("dec_sat_%0d", i), dec_exp[i], 1'b0, 0);

    // Both octave buttons.
    press_clr(0);
    inc_octave = 1'b1; dec_octave = 1'b1; tick(1);
    expect_now("inc_dec_same_edge", 4, 0, 0, 0, 0);
    tick(10);
    expect_now("inc_dec_both_held", 4, 0, 0, 0, 0);
    inc_octave = 1'b0; dec_octave = 1'b0; tick(1);
    inc_octave = 1'b1; tick(1);
    expect_now("inc_then", 5, 0, 0, 0, 0);
    dec_octave = 1'b1; tick(1);
    expect_now("dec_while_inc_held", 5, 0, 0, 0, 0);
    tick(10);
    expect_now("staggered_both_held", 5, 0, 0, 0, 0);
    inc_octave = 1'b0; dec_octave = 1'b0; tick(1);

    // Playback toggle and clear priority.
    toggle_pb = 1'b1; tick(1);
    expect_now("toggle_on", 5, 1, 0, 0, 0);
    toggle_pb = 1'b0; tick(1);
    press_inc("inc_in_playback", 6, 1'b1, 0);
    rst = 1'b1; toggle_pb = 1'b1; tick(1);
    expect_now("clear_beats_toggle", 4, 0, 0, 0, 0);
    rst = 1'b0; toggle_pb = 1'b0; tick(1);

    // Notes.
    note_switches = 7'b0010100; tick(1);
    expect_now("note_e_on", 4, 0, 1, 2, 0);
    tick(1);
    expect_now("note_e_pulse", 4, 0, 1, 2, 1);
    tick(1);
    expect_now("note_e_pulse_end", 4, 0, 1, 2, 0);
    note_switches = 7'b0000000; tick(1);
    expect_now("note_off_hold_idx", 4, 0, 0, 2, 0);
    tick(1);
    expect_now("note_off_pulse", 4, 0, 0, 2, 1);
    tick(1);
    expect_now("note_off_pulse_end", 4, 0, 0, 2, 0);
    note_switches = 7'b1111111; tick(2);
    expect_now("note_all_c_wins", 4, 0, 1, 0, 1);
    note_switches = 7'b0000001; tick(1);
    expect_now("note_b_only", 4, 0, 1, 6, 0);
    note_switches = 7'b0000000; tick(3);
    expect_now("note_b_released", 4, 0, 0, 6, 0);

    // Hold from octave 0: repeat steps only when the feature is built in.
    for (int i = 0; i < 4; i++) press_dec($sformatf("to_zero_%0d", i), 3 - i, 1'b0, 6);
    inc_octave = 1'b1; tick(1);
    expect_now("hold_press_edge", 1, 0, 0, 6, 0);
    tick(7);
    expect_now("hold_plus7", 1, 0, 0, 6, 0);
    tick(1);
    expect_now("hold_plus8", REP ? 2 : 1, 0, 0, 6, 0);
    tick(8);
    expect_now("hold_plus16", REP ? 3 : 1, 0, 0, 6, 0);
    tick(3);
    inc_octave = 1'b0; tick(11);
    expect_now("hold_released", REP ? 3 : 1, 0, 0, 6, 0);

    // Reset pulse during an active hold.
    press_clr(6);
    for (int i = 0; i < 4; i++) press_dec($sformatf("to_zero_b_%0d", i), 3 - i, 1'b0, 6);
    toggle_pb = 1'b1; tick(1);
    toggle_pb = 1'b0;
    inc_octave = 1'b1; tick(1);
    expect_now("hold2_press", 1, 1, 0, 6, 0);
    tick(5);
    rst_n = 1'b0; #1;
    expect_now("async_reset", 4, 0, 0, 0, 0);
    tick(1);
    rst_n = 1'b1; tick(12);
    expect_now("no_step_after_reset", 4, 0, 0, 0, 0);
    inc_octave = 1'b0; tick(1);
    inc_octave = 1'b1; tick(1);
    expect_now("repress_after_reset", 5, 0, 0, 0, 0);
    inc_octave = 1'b0; tick(2);

    finishing = 1'b1;
    for (int i = 0; i < 5 && !mon_done; i++) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
